// File: rtl/pc_branch_unit_pkg.sv
// Shared types and constants for the PC / branch-resolution stage.
// Used by pc_branch_unit and branch_cond_decode.
package pc_branch_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [31:0] PC_RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VECTOR_DEF  = 32'h0000_0100;

    function automatic logic [31:0] pc_inc4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_branch_unit_branch_cond_decode.sv
// Combinational branch condition decode: funct3 plus comparator flags
// give the taken condition and an illegal-encoding flag.
module branch_cond_decode
    import pc_branch_unit_pkg::*;
(
    input  logic [2:0] Funct3,
    input  logic       Equal,
    input  logic       Lt,
    output logic       Cond,
    output logic       Illegal
);

    always_comb begin
        Cond    = 1'b0;
        Illegal = 1'b0;
        case (Funct3)
            F3_BEQ:  Cond = Equal;
            F3_BNE:  Cond = ~Equal;
            F3_BLT:  Cond = Lt;
            F3_BGE:  Cond = ~Lt;
            F3_BLTU: Cond = Lt;
            F3_BGEU: Cond = ~Lt;
            default: Illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Program-counter stage: branch/jump redirect, PC register, fetch handshake,
// halt on illegal branch encoding. Optional macro PC_MISALIGN_TRAP_EN.
module pc_branch_unit
    import pc_branch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR_DEF,
    parameter logic [31:0] TRAP_VECTOR  = PC_TRAP_VECTOR_DEF
) (
    input  logic        Clk,
    input  logic        Reset_N,
    input  logic        Branch_Ctrl,
    input  logic        Jump_Ctrl,
    input  logic [2:0]  Branch_Funct3,
    input  logic        Branch_Equal,
    input  logic        Branch_Lt,
    input  logic [31:0] Target_Addr,
    input  logic        Fetch_Ready,
    output logic        Branch_Un_Ctrl,
    output logic [31:0] PC,
    output logic [31:0] PC_Plus_4,
    output logic        Fetch_Valid,
    output logic        Branch_Taken,
    output logic        Illegal_Branch,
    output logic        Misalign_Trap
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        illegal_q, illegal_d;

    logic        cond;
    logic        illegal_f3;
    logic        in_run;
    logic        illegal_hit;
    logic        redirect;
    logic [31:0] sel_target;
    logic [31:0] pc_plus4;

    branch_cond_decode u_cond (
        .Funct3  (Branch_Funct3),
        .Equal   (Branch_Equal),
        .Lt      (Branch_Lt),
        .Cond    (cond),
        .Illegal (illegal_f3)
    );

    always_comb begin
        in_run      = (state_q == ST_RUN);
        illegal_hit = Branch_Ctrl & illegal_f3;
        // An illegal branch suppresses any redirect, even alongside a jump.
        redirect    = in_run & ~illegal_hit & (Jump_Ctrl | (Branch_Ctrl & cond));
        sel_target  = Jump_Ctrl ? {Target_Addr[31:1], 1'b0} : Target_Addr;
        pc_plus4    = pc_inc4(pc_q);
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic trap_q, trap_d;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        illegal_d = illegal_q;
`ifdef PC_MISALIGN_TRAP_EN
        trap_d    = 1'b0;
`endif
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (Fetch_Ready) begin
                    if (illegal_hit) begin
                        state_d   = ST_HALT;
                        illegal_d = 1'b1;
                    end else if (redirect) begin
`ifdef PC_MISALIGN_TRAP_EN
                        if (sel_target[1:0] != 2'b00) begin
                            pc_d   = TRAP_VECTOR;
                            trap_d = 1'b1;
                        end else begin
                            pc_d = sel_target;
                        end
`else
                        pc_d = sel_target & ~32'd3;
`endif
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_VECTOR;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end

    assign Misalign_Trap = trap_q;
`else
    assign Misalign_Trap = 1'b0;
`endif

    assign Branch_Un_Ctrl = Branch_Funct3[1];
    assign PC             = pc_q;
    assign PC_Plus_4      = pc_plus4;
    assign Fetch_Valid    = in_run;
    assign Branch_Taken   = redirect;
    assign Illegal_Branch = illegal_q;

endmodule
